regfile_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the 8×16-bit register file (x0 reads as zero; one write port written on every clock edge, no write enable). It shares the single write port between the ALU and load/store unit (LSU) writeback requesters with a 2-way round-robin handshake. It drives the register file's `tgt`/`tgt_dat` from a registered output stage, and tracks in-flight destinations so the issue stage stalls on RAW/WAW hazards.

---
 rtl/tinyrv_pkg.sv | 9 +
 rtl/rr_arb2.sv | 25 ++
 rtl/regfile_wb_sched.sv | 78 +++++++
 tb/tb_regfile_wb_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tinyrv_pkg.sv
// rtl/tinyrv_pkg.sv - shared register-file widths and types
package tinyrv_pkg;
  localparam int XLEN   = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic pref_q, pref_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = pref_q ? 2'b10 : 2'b01;
  end

  // The winner yields priority to the other requester next time.
  always_comb begin
    pref_d = pref_q;
    if (gnt != 2'b00) pref_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pref_q <= 1'b0;
    else        pref_q <= pref_d;
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - writeback arbitration, output stage and busy scoreboard
module regfile_wb_sched
  import tinyrv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rd,
  input  reg_idx_t        iss_rs1,
  input  reg_idx_t        iss_rs2,
  output logic            iss_hazard,
  input  logic            alu_valid,
  input  reg_idx_t        alu_rd,
  input  word_t           alu_dat,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  reg_idx_t        lsu_rd,
  input  word_t           lsu_dat,
  output logic            lsu_ready,
  output reg_idx_t        rf_tgt,
  output word_t           rf_tgt_dat,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] busy_q, busy_d;
  reg_idx_t        tgt_q, tgt_d;
  word_t           dat_q, dat_d;
  logic [1:0]      gnt;
  logic            iss_accept;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready  = gnt[0];
  assign lsu_ready  = gnt[1];
  assign iss_hazard = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
  assign iss_accept = iss_valid & ~iss_hazard;

  // Idle cycles target x0 so the unconditional register-file write is harmless.
  always_comb begin
    tgt_d = '0;
    dat_d = '0;
    if (gnt[0]) begin
      tgt_d = alu_rd;
      dat_d = alu_dat;
    end else if (gnt[1]) begin
      tgt_d = lsu_rd;
      dat_d = lsu_dat;
    end
  end

  // Clear and set never hit the same bit: issue requires the rd bit to be idle.
  always_comb begin
    busy_d         = busy_q;
    busy_d[tgt_q]  = 1'b0;
    if (iss_accept && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0]      = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      tgt_q  <= '0;
      dat_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tgt_q  <= tgt_d;
      dat_q  <= dat_d;
    end
  end

  assign rf_tgt     = tgt_q;
  assign rf_tgt_dat = dat_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - directed self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [2:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_hazard;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_dat;
  logic        alu_ready;
  logic        lsu_valid;
  logic [2:0]  lsu_rd;
  logic [15:0] lsu_dat;
  logic        lsu_ready;
  logic [2:0]  rf_tgt;
  logic [15:0] rf_tgt_dat;
  logic [7:0]  busy;

  int tests = 0;
  int fails = 0;

  regfile_wb_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_hazard (iss_hazard),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_dat    (alu_dat),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_dat    (lsu_dat),
    .lsu_ready  (lsu_ready),
    .rf_tgt     (rf_tgt),
    .rf_tgt_dat (rf_tgt_dat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_dat = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_dat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("rst_busy", busy, 8'h00);
      chk("rst_tgt", rf_tgt, 3'd0);
      chk("rst_dat", rf_tgt_dat, 16'h0);
      chk("rst_rdy", {alu_ready, lsu_ready}, 2'b00);
      next_cycle();
    end

    // RAW hazard on x3
    iss_valid = 1; iss_rd = 3; iss_rs1 = 0; iss_rs2 = 0;
    mid();
    chk("raw_c0_haz", iss_hazard, 1'b0);
    next_cycle();
    iss_rd = 4; iss_rs1 = 3;
    mid();
    chk("raw_c1_busy", busy, 8'h08);
    chk("raw_c1_haz", iss_hazard, 1'b1);
    next_cycle();
    alu_valid = 1; alu_rd = 3; alu_dat = 16'h1234;
    mid();
    chk("raw_c2_rdy", alu_ready, 1'b1);
    chk("raw_c2_haz", iss_hazard, 1'b1);
    next_cycle();
    alu_valid = 0;
    mid();
    chk("raw_c3_tgt", rf_tgt, 3'd3);
    chk("raw_c3_dat", rf_tgt_dat, 16'h1234);
    chk("raw_c3_busy", busy, 8'h08);
    chk("raw_c3_haz", iss_hazard, 1'b1);
    next_cycle();
    mid();
    chk("raw_c4_busy", busy, 8'h00);
    chk("raw_c4_haz", iss_hazard, 1'b0);
    chk("raw_c4_tgt", rf_tgt, 3'd0);
    next_cycle();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 4; alu_dat = 16'h0042;
    mid();
    chk("raw_c5_busy", busy, 8'h10);
    chk("raw_c5_rdy", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 0;
    mid();
    chk("raw_c6_tgt", rf_tgt, 3'd4);
    next_cycle();
    mid();
    chk("raw_c7_busy", busy, 8'h00);

    // Both requesters continuously valid from reset
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_dat = 16'hAAAA;
    lsu_valid = 1; lsu_rd = 2; lsu_dat = 16'hBBBB;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("alt_gnt", {alu_ready, lsu_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_tgt", rf_tgt, (k == 0) ? 3'd0 : (((k - 1) % 2 == 0) ? 3'd1 : 3'd2));
      next_cycle();
    end
    alu_valid = 0; lsu_valid = 0;
    next_cycle();

    // LSU alone three times, then contention goes to ALU
    do_reset();
    lsu_valid = 1; lsu_rd = 2; lsu_dat = 16'hC0DE;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("lsu_only_gnt", {alu_ready, lsu_ready}, 2'b01);
      next_cycle();
    end
    alu_valid = 1; alu_rd = 1; alu_dat = 16'h0101;
    mid();
    chk("lsu_prev_tgt", rf_tgt, 3'd2);
    chk("lsu_prev_dat", rf_tgt_dat, 16'hC0DE);
    chk("contend_gnt", {alu_ready, lsu_ready}, 2'b10);
    next_cycle();
    alu_valid = 0; lsu_valid = 0;
    next_cycle();

    // rd=0 issue and writeback
    do_reset();
    iss_valid = 1; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_valid = 1; alu_rd = 0; alu_dat = 16'hFFFF;
    mid();
    chk("x0_haz", iss_hazard, 1'b0);
    chk("x0_rdy", alu_ready, 1'b1);
    next_cycle();
    iss_valid = 0; alu_valid = 0;
    mid();
    chk("x0_busy", busy, 8'h00);
    chk("x0_tgt", rf_tgt, 3'd0);
    chk("x0_dat", rf_tgt_dat, 16'hFFFF);

    // Asynchronous reset mid-flight
    do_reset();
    iss_valid = 1; iss_rd = 5;
    next_cycle();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 5; alu_dat = 16'h55AA;
    mid();
    chk("ar_busy_set", busy, 8'h20);
    chk("ar_rdy", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 0;
    mid();
    chk("ar_tgt_pre", rf_tgt, 3'd5);
    chk("ar_busy_pre", busy, 8'h20);
    rst_n = 0;
    #1;
    chk("ar_busy_rst", busy, 8'h00);
    chk("ar_tgt_rst", rf_tgt, 3'd0);
    chk("ar_dat_rst", rf_tgt_dat, 16'h0);
    #1;
    rst_n = 1;
    next_cycle();
    alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2;
    mid();
    chk("ar_pref", {alu_ready, lsu_ready}, 2'b10);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
